// File: rtl/color_corrector_csr_bank_if.sv
// ============================================================================
// Module   : axi4_lite_if
// Brief    : 32-bit address / 32-bit data AXI4-Lite bundle for the CSR bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi4_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/color_corrector_csr_bank.sv
// ============================================================================
// Module   : color_corrector_csr_bank
// Brief    : AXI4-Lite CSR bank with double-buffered colour coefficients,
//            committed atomically on frame start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_corrector_csr_bank #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          COEF_CNT  = 12,
    parameter int          COEF_W    = 20
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    axi4_lite_if.slave                   csr_i,
    input  logic                         sof_i,
    output logic [COEF_CNT*COEF_W-1:0]   coef_o,
    output logic                         bypass_o,
    output logic                         commit_o
);

    localparam int                 c_sel_w       = $clog2(COEF_CNT);
    localparam logic [31:0]        c_cnt         = COEF_CNT;
    localparam logic [c_sel_w-1:0] c_sel_one     = c_sel_w'(1);
    localparam logic [1:0]         c_resp_okay   = 2'b00;
    localparam logic [1:0]         c_resp_slverr = 2'b10;
    localparam logic [29:0]        c_idx_ctrl    = 30'd0;
    localparam logic [29:0]        c_idx_status  = 30'd1;
    localparam logic [29:0]        c_idx_sel     = 30'd2;
    localparam logic [29:0]        c_idx_shadow  = 30'd3;
    localparam logic [29:0]        c_idx_active  = 30'd4;

    logic [COEF_W-1:0]  r_shadow [COEF_CNT];
    logic [COEF_W-1:0]  r_active [COEF_CNT];
    logic               r_pending;
    logic               r_auto_commit;
    logic               r_bypass;
    logic               r_auto_inc;
    logic [c_sel_w-1:0] r_sel;
    logic [7:0]         r_commit_cnt;
    logic               r_commit;

    logic               r_aw_held;
    logic [31:0]        r_awaddr;
    logic               r_w_held;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_bvalid;
    logic [1:0]         r_bresp;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;

    logic               w_awready;
    logic               w_wready;
    logic [31:0]        w_woff;
    logic [29:0]        w_widx;
    logic [31:0]        w_roff;
    logic [29:0]        w_ridx;
    logic [31:0]        w_sel32;
    logic               w_sel_ok;
    logic               w_sel_last;
    logic [c_sel_w-1:0] w_sel_idx;
    logic               w_wr_fire;
    logic               w_wr_err;
    logic               w_wr_ok;
    logic               w_ctrl_wr;
    logic               w_sel_wr;
    logic               w_shadow_wr;
    logic               w_commit;
    logic [31:0]        w_wmask;
    logic [31:0]        w_shadow_cur;
    logic [31:0]        w_merged;
    logic [COEF_W-1:0]  w_shadow_new;
    logic [31:0]        w_rd_data;
    logic               w_rd_err;
    logic               w_unused;

    // A captured channel blocks itself until its partner arrives; a pending
    // response blocks both.
    assign w_awready = !r_aw_held && !r_bvalid;
    assign w_wready  = !r_w_held && !r_bvalid;

    assign csr_i.awready = w_awready;
    assign csr_i.wready  = w_wready;
    assign csr_i.bvalid  = r_bvalid;
    assign csr_i.bresp   = r_bresp;
    assign csr_i.arready = !r_rvalid;
    assign csr_i.rvalid  = r_rvalid;
    assign csr_i.rdata   = r_rdata;
    assign csr_i.rresp   = r_rresp;

    assign w_woff     = r_awaddr - BASE_ADDR;
    assign w_widx     = w_woff[31:2];
    assign w_roff     = csr_i.araddr - BASE_ADDR;
    assign w_ridx     = w_roff[31:2];
    assign w_sel32    = 32'(r_sel);
    assign w_sel_ok   = w_sel32 < c_cnt;
    assign w_sel_last = w_sel32 == (c_cnt - 32'd1);
    assign w_sel_idx  = w_sel_ok ? r_sel : '0;

    assign w_wr_fire   = r_aw_held && r_w_held;
    assign w_wr_ok     = w_wr_fire && !w_wr_err;
    assign w_ctrl_wr   = w_wr_ok && (w_widx == c_idx_ctrl) && r_wstrb[0];
    assign w_sel_wr    = w_wr_ok && (w_widx == c_idx_sel) && r_wstrb[0];
    assign w_shadow_wr = w_wr_ok && (w_widx == c_idx_shadow);
    assign w_commit    = sof_i && (r_pending || r_auto_commit);

    assign w_wmask      = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
    assign w_shadow_cur = 32'(r_shadow[w_sel_idx]);
    assign w_merged     = (w_shadow_cur & ~w_wmask) | (r_wdata & w_wmask);
    assign w_shadow_new = w_merged[COEF_W-1:0];

    assign w_unused = ^{w_woff[1:0], w_roff[1:0], w_merged};

    always_comb begin
        w_wr_err = 1'b0;
        case (w_widx)
            c_idx_ctrl, c_idx_status, c_idx_sel: w_wr_err = 1'b0;
            c_idx_shadow, c_idx_active:          w_wr_err = !w_sel_ok;
            default:                             w_wr_err = 1'b1;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (w_ridx)
            c_idx_ctrl:   w_rd_data = {28'd0, r_auto_inc, r_bypass, r_auto_commit, r_pending};
            c_idx_status: w_rd_data = {16'd0, r_commit_cnt, 7'd0, r_pending};
            c_idx_sel:    w_rd_data = w_sel32;
            c_idx_shadow: begin
                if (w_sel_ok) w_rd_data = 32'(r_shadow[w_sel_idx]);
                else          w_rd_err  = 1'b1;
            end
            c_idx_active: begin
                if (w_sel_ok) w_rd_data = 32'(r_active[w_sel_idx]);
                else          w_rd_err  = 1'b1;
            end
            default:      w_rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin : p_wr_chan
        if (!rst_n_i) begin
            r_aw_held <= 1'b0;
            r_awaddr  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_okay;
        end else begin
            if (csr_i.awvalid && w_awready) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= csr_i.awaddr;
            end
            if (csr_i.wvalid && w_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= csr_i.wdata;
                r_wstrb  <= csr_i.wstrb;
            end
            if (w_wr_fire) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_err ? c_resp_slverr : c_resp_okay;
            end else if (r_bvalid && csr_i.bready) begin
                r_bvalid <= 1'b0;
                r_bresp  <= c_resp_okay;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin : p_rd_chan
        if (!rst_n_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_resp_okay;
        end else if (csr_i.arvalid && !r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_err ? 32'd0 : w_rd_data;
            r_rresp  <= w_rd_err ? c_resp_slverr : c_resp_okay;
        end else if (r_rvalid && csr_i.rready) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_resp_okay;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin : p_ctrl
        if (!rst_n_i) begin
            r_pending     <= 1'b0;
            r_auto_commit <= 1'b0;
            r_bypass      <= 1'b0;
            r_auto_inc    <= 1'b0;
            r_sel         <= '0;
            r_commit_cnt  <= '0;
            r_commit      <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_auto_commit <= r_wdata[1];
                r_bypass      <= r_wdata[2];
                r_auto_inc    <= r_wdata[3];
            end
            // A fresh arm wins over a concurrent commit so it is not lost.
            if (w_ctrl_wr && r_wdata[0]) r_pending <= 1'b1;
            else if (w_commit)           r_pending <= 1'b0;
            if (w_commit) r_commit_cnt <= r_commit_cnt + 8'd1;
            r_commit <= w_commit;
            if (w_sel_wr)                       r_sel <= r_wdata[c_sel_w-1:0];
            else if (w_shadow_wr && r_auto_inc) r_sel <= w_sel_last ? '0 : r_sel + c_sel_one;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin : p_bank
        if (!rst_n_i) begin
            for (int k = 0; k < COEF_CNT; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else begin
            if (w_commit) begin
                for (int k = 0; k < COEF_CNT; k++) r_active[k] <= r_shadow[k];
            end
            if (w_shadow_wr) r_shadow[w_sel_idx] <= w_shadow_new;
        end
    end

    for (genvar k = 0; k < COEF_CNT; k++) begin : g_coef
        assign coef_o[(k+1)*COEF_W-1 -: COEF_W] = r_active[k];
    end

    assign bypass_o = r_bypass;
    assign commit_o = r_commit;

endmodule

`default_nettype wire

// File: tb/tb_color_corrector_csr_bank.sv
// ============================================================================
// Module   : tb_color_corrector_csr_bank
// Brief    : Self-checking bench for color_corrector_csr_bank against a
//            register-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_color_corrector_csr_bank;

    localparam int          CNT      = 12;
    localparam int          CW       = 20;
    localparam logic [31:0] A_CTRL   = 32'd0;
    localparam logic [31:0] A_STATUS = 32'd4;
    localparam logic [31:0] A_SEL    = 32'd8;
    localparam logic [31:0] A_SHADOW = 32'd12;
    localparam logic [31:0] A_ACTIVE = 32'd16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                sof = 1'b0;
    logic [CNT*CW-1:0]   coef;
    logic                bypass;
    logic                commit;

    axi4_lite_if bus ();

    color_corrector_csr_bank #(
        .BASE_ADDR (32'h0000_0000),
        .COEF_CNT  (CNT),
        .COEF_W    (CW)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .csr_i    (bus),
        .sof_i    (sof),
        .coef_o   (coef),
        .bypass_o (bypass),
        .commit_o (commit)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [CW-1:0] m_shadow [CNT];
    logic [CW-1:0] m_active [CNT];
    bit            m_pending, m_auto_commit, m_bypass, m_auto_inc;
    int            m_sel, m_cnt;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < CNT; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_pending = 0; m_auto_commit = 0; m_bypass = 0; m_auto_inc = 0;
        m_sel = 0; m_cnt = 0;
    endfunction

    function automatic void model_commit();
        for (int k = 0; k < CNT; k++) m_active[k] = m_shadow[k];
        m_pending = 0;
        m_cnt = (m_cnt + 1) % 256;
    endfunction

    function automatic logic [255:0] model_coef();
        logic [255:0] v = '0;
        for (int k = 0; k < CNT; k++) v[k*CW +: CW] = m_active[k];
        return v;
    endfunction

    // Applies a write to the model and returns the response it should get.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask, merged;
        int idx = int'(a >> 2);
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
        case (idx)
            0: begin
                if (s[0]) begin
                    if (d[0]) m_pending = 1;
                    m_auto_commit = d[1]; m_bypass = d[2]; m_auto_inc = d[3];
                end
                return 2'b00;
            end
            1: return 2'b00;
            2: begin
                if (s[0]) m_sel = int'(d[3:0]);
                return 2'b00;
            end
            3: begin
                if (m_sel >= CNT) return 2'b10;
                merged = ({12'd0, m_shadow[m_sel]} & ~mask) | (d & mask);
                m_shadow[m_sel] = merged[CW-1:0];
                if (m_auto_inc) m_sel = (m_sel + 1) % CNT;
                return 2'b00;
            end
            4: return (m_sel >= CNT) ? 2'b10 : 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a);
        int idx = int'(a >> 2);
        case (idx)
            0: return {2'b00, 28'd0, m_auto_inc, m_bypass, m_auto_commit, m_pending};
            1: return {2'b00, 16'd0, 8'(m_cnt), 7'd0, m_pending};
            2: return {2'b00, 32'(m_sel)};
            3: return (m_sel >= CNT) ? {2'b10, 32'd0} : {2'b00, 12'd0, m_shadow[m_sel]};
            4: return (m_sel >= CNT) ? {2'b10, 32'd0} : {2'b00, 12'd0, m_active[m_sel]};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        @(negedge clk);
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.wvalid = 1'b0; end
            n++;
        end
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
        chk("wr_resp_wait", n < 50, 1);
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        bus.araddr = a; bus.arvalid = 1'b1;
        while (!bus.arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
        chk("rd_wait", n < 50, 1);
        d = bus.rdata; resp = bus.rresp;
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] exp_r, got_r;
        exp_r = model_write(a, d, s);
        axi_write(a, d, s, got_r);
        chk({tag, "_bresp"}, got_r, exp_r);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a);
        logic [33:0] e;
        logic [31:0] d;
        logic [1:0]  r;
        e = model_read(a);
        axi_read(a, d, r);
        chk({tag, "_rdata"}, d, e[31:0]);
        chk({tag, "_rresp"}, r, e[33:32]);
    endtask

    task automatic pulse_sof(input string tag);
        bit exp_c = m_pending || m_auto_commit;
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        if (exp_c) model_commit();
        chk({tag, "_commit"}, commit, exp_c);
        chk({tag, "_coef"}, coef, model_coef());
    endtask

    // Write whose register-update edge coincides with a sof_i pulse.
    task automatic write_with_sof(input string tag, input logic [31:0] a, input logic [31:0] d);
        bit exp_c = m_pending || m_auto_commit;
        logic [1:0] exp_r;
        @(negedge clk);
        chk({tag, "_ready"}, {bus.awready, bus.wready}, 2'b11);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        if (exp_c) model_commit();
        exp_r = model_write(a, d, 4'hF);
        chk({tag, "_commit"}, commit, exp_c);
        chk({tag, "_bvalid"}, bus.bvalid, 1);
        chk({tag, "_bresp"}, bus.bresp, exp_r);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  r;
        int          pulses;

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_coef", coef, '0);
        chk("rst_bypass", bypass, 0);
        chk("rst_commit", commit, 0);
        chk("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        chk("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("rst_rdata", bus.rdata, 0);

        // Fill the bank through auto-increment, then arm and commit.
        do_write("ctrl_ainc", A_CTRL, 32'h8, 4'hF);
        for (int k = 0; k < CNT; k++) do_write("fill", A_SHADOW, $urandom, 4'hF);
        do_read("sel_wrapped", A_SEL);
        do_read("shadow0", A_SHADOW);
        do_read("active0_pre", A_ACTIVE);
        do_write("ctrl_arm", A_CTRL, 32'h9, 4'hF);
        do_read("ctrl_pending", A_CTRL);
        pulse_sof("commit1");
        @(negedge clk);
        chk("commit1_pulse_end", commit, 0);
        do_read("status1", A_STATUS);
        chk("status1_literal", model_read(A_STATUS), {2'b00, 32'h0000_0100});

        // Random byte-strobed shadow updates with readback.
        do_write("ctrl_plain", A_CTRL, 32'h0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            do_write("sel_rand", A_SEL, $urandom_range(CNT-1, 0), 4'hF);
            d = $urandom;
            s = 4'($urandom_range(15, 0));
            do_write("shadow_strb", A_SHADOW, d, s);
            do_read("shadow_strb_rb", A_SHADOW);
        end
        pulse_sof("idle_sof");

        // AW leads W by 5 cycles.
        @(negedge clk);
        bus.awaddr = A_SEL; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("aw_lead_awready", bus.awready, 0);
            chk("aw_lead_bvalid", bus.bvalid, 0);
            @(negedge clk);
        end
        bus.wdata = 32'd5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        r = model_write(A_SEL, 32'd5, 4'hF);
        @(negedge clk);
        chk("aw_lead_bvalid_up", bus.bvalid, 1);
        chk("aw_lead_bresp", bus.bresp, r);
        for (int i = 0; i < 3; i++) begin
            chk("bhold_readies", {bus.awready, bus.wready, bus.bvalid}, 3'b001);
            @(negedge clk);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("single_bvalid", bus.bvalid, 0);
            @(negedge clk);
        end
        do_read("aw_lead_sel", A_SEL);
        chk("rdata_cleared", bus.rdata, 0);

        // Unmapped and out-of-range accesses.
        do_read("unmapped7", 32'd28);
        do_write("unmapped7_wr", 32'd28, 32'h1234, 4'hF);
        do_write("sel12", A_SEL, 32'd12, 4'hF);
        do_read("shadow_oor", A_SHADOW);
        do_read("active_oor", A_ACTIVE);
        do_write("shadow_oor_wr", A_SHADOW, 32'hFFFF_FFFF, 4'hF);
        for (int k = 0; k < CNT; k += 5) begin
            do_write("sel_scan", A_SEL, k, 4'hF);
            do_read("shadow_unchanged", A_SHADOW);
        end

        // Shadow write landing on a committing sof.
        do_write("sel4", A_SEL, 32'd4, 4'hF);
        do_write("arm2", A_CTRL, 32'h1, 4'hF);
        write_with_sof("wsof_shadow", A_SHADOW, 32'h000A_BCDE);
        chk("wsof_coef", coef, model_coef());
        do_read("wsof_shadow_rb", A_SHADOW);
        do_write("arm3", A_CTRL, 32'h1, 4'hF);
        pulse_sof("commit3");
        chk("commit3_slot4", coef[4*CW +: CW], 20'hABCDE);

        // Arm landing on a sof with nothing pending.
        write_with_sof("wsof_arm", A_CTRL, 32'h1);
        do_read("wsof_arm_ctrl", A_CTRL);
        pulse_sof("commit4");

        // 256 auto-commits wrap the counter.
        do_write("ctrl_auto", A_CTRL, 32'h2, 4'hF);
        pulses = 0;
        for (int i = 0; i < 512; i++) begin
            sof = (i % 2 == 0);
            @(negedge clk);
            if (commit) pulses++;
        end
        sof = 1'b0;
        @(negedge clk);
        if (commit) pulses++;
        for (int i = 0; i < 256; i++) model_commit();
        chk("auto_pulses", pulses, 256);
        do_write("ctrl_bypass", A_CTRL, 32'h4, 4'hF);
        do_read("status_wrap", A_STATUS);
        chk("bypass_on", bypass, 1);
        chk("auto_coef", coef, model_coef());

        // Reset with a read response pending and a lone W captured.
        @(negedge clk);
        bus.araddr = A_SEL; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.wdata = 32'h7; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        chk("pre_rst_rvalid", bus.rvalid, 1);
        chk("pre_rst_wready", bus.wready, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valids", {bus.rvalid, bus.bvalid}, 2'b00);
        chk("mid_rst_coef", coef, '0);
        chk("mid_rst_bypass", bypass, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        do_write("post_rst_sel", A_SEL, 32'd3, 4'hF);
        do_read("post_rst_sel_rb", A_SEL);
        do_read("post_rst_shadow", A_SHADOW);
        do_read("post_rst_status", A_STATUS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
